// File: rtl/axi4l__aligned_acc_m_if.sv
// AXI4-Lite master bridge: single-word aligned acc__* requests become AXI4-Lite write/read transactions.
// Optional macro AXI4L_M_TIMEOUT_EN adds per-channel timeout, a DRAIN state and the acc__timeout flag.
module axi4l__aligned_acc_m_if #(
    parameter int unsigned axi4l__addr_width = 64,
    parameter int unsigned axi4l__data_width = 32,
    parameter logic [2:0]  axi4l__prot       = 3'b000,
    parameter int unsigned timeout_cycles    = 1024
) (
    input  logic                         sys__clk,
    input  logic                         sys__arst,
    input  logic [axi4l__addr_width-1:0] acc__waddr,
    input  logic [axi4l__data_width-1:0] acc__wdata,
    input  logic                         acc__wvalid,
    output logic                         acc__wready,
    output logic                         acc__werr,
    input  logic [axi4l__addr_width-1:0] acc__raddr,
    input  logic                         acc__rvalid,
    output logic                         acc__rready,
    output logic [axi4l__data_width-1:0] acc__rdata,
    output logic                         acc__rerr,
    output logic [axi4l__addr_width-1:0] axi4l__m_awaddr,
    output logic [2:0]                   axi4l__m_awprot,
    output logic                         axi4l__m_awvalid,
    input  logic                         axi4l__m_awready,
    output logic [axi4l__data_width-1:0] axi4l__m_wdata,
    output logic [axi4l__data_width/8-1:0] axi4l__m_wstrb,
    output logic                         axi4l__m_wvalid,
    input  logic                         axi4l__m_wready,
    input  logic [1:0]                   axi4l__m_bresp,
    input  logic                         axi4l__m_bvalid,
    output logic                         axi4l__m_bready,
    output logic [axi4l__addr_width-1:0] axi4l__m_araddr,
    output logic [2:0]                   axi4l__m_arprot,
    output logic                         axi4l__m_arvalid,
    input  logic                         axi4l__m_arready,
    input  logic [axi4l__data_width-1:0] axi4l__m_rdata,
    input  logic [1:0]                   axi4l__m_rresp,
    input  logic                         axi4l__m_rvalid,
    output logic                         axi4l__m_rready
`ifdef AXI4L_M_TIMEOUT_EN
    ,
    output logic                         acc__timeout
`endif
);

    localparam int unsigned AW = axi4l__addr_width;
    localparam int unsigned DW = axi4l__data_width;
    localparam int unsigned SW = DW / 8;
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(SW - 1);

    // Reject illegal configurations at elaboration.
    if (!(DW == 32 || DW == 64) || timeout_cycles < 2 || timeout_cycles > 65536) begin : g_bad_cfg
        $error("axi4l__aligned_acc_m_if: illegal data width or timeout_cycles");
    end

`ifdef AXI4L_M_TIMEOUT_EN
    typedef enum logic [4:0] {
        W_IDLE = 5'b00001, W_ADDR = 5'b00010, W_RESP = 5'b00100, W_DONE = 5'b01000, W_DRAIN = 5'b10000
    } wstate_t;
    typedef enum logic [2:0] {R_IDLE, R_ADDR, R_DATA, R_DONE, R_DRAIN} rstate_t;
    localparam logic [15:0] TO_LAST = 16'(timeout_cycles - 1);
    logic [15:0] wcnt, rcnt;
    logic        w_to_fire, r_to_fire;
`else
    typedef enum logic [3:0] {
        W_IDLE = 4'b0001, W_ADDR = 4'b0010, W_RESP = 4'b0100, W_DONE = 4'b1000
    } wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rstate_t;
`endif

    wstate_t wstate;
    rstate_t rstate;
    logic    aw_ok, w_ok;

    assign axi4l__m_awprot = axi4l__prot;
    assign axi4l__m_arprot = axi4l__prot;
    assign axi4l__m_wstrb  = '1;

    // A channel counts as done once its valid is low or is being accepted this cycle.
    assign aw_ok = !axi4l__m_awvalid || axi4l__m_awready;
    assign w_ok  = !axi4l__m_wvalid  || axi4l__m_wready;

`ifdef AXI4L_M_TIMEOUT_EN
    assign w_to_fire = (wcnt == TO_LAST) &&
                       (((wstate == W_ADDR) && !(aw_ok && w_ok)) ||
                        ((wstate == W_RESP) && !axi4l__m_bvalid));
    assign r_to_fire = (rcnt == TO_LAST) &&
                       (((rstate == R_ADDR) && !axi4l__m_arready) ||
                        ((rstate == R_DATA) && !axi4l__m_rvalid));

    always_ff @(posedge sys__clk or posedge sys__arst) begin
        if (sys__arst) acc__timeout <= 1'b0;
        else if (w_to_fire || r_to_fire) acc__timeout <= 1'b1;
    end
`endif

    // Write channel: AW and W issued together, retired independently, then B.
    always_ff @(posedge sys__clk or posedge sys__arst) begin
        if (sys__arst) begin
            wstate           <= W_IDLE;
            axi4l__m_awaddr  <= '0;
            axi4l__m_wdata   <= '0;
            axi4l__m_awvalid <= 1'b0;
            axi4l__m_wvalid  <= 1'b0;
            axi4l__m_bready  <= 1'b0;
            acc__wready      <= 1'b0;
            acc__werr        <= 1'b0;
`ifdef AXI4L_M_TIMEOUT_EN
            wcnt             <= '0;
`endif
        end else begin
            if (axi4l__m_awvalid && axi4l__m_awready) axi4l__m_awvalid <= 1'b0;
            if (axi4l__m_wvalid && axi4l__m_wready)   axi4l__m_wvalid  <= 1'b0;
            if (axi4l__m_bready && axi4l__m_bvalid)   axi4l__m_bready  <= 1'b0;
            acc__wready <= 1'b0;
`ifdef AXI4L_M_TIMEOUT_EN
            wcnt <= (wstate == W_ADDR || wstate == W_RESP) ? wcnt + 16'd1 : 16'd0;
`endif
            case (wstate)
                W_IDLE: if (acc__wvalid) begin
                    axi4l__m_awaddr  <= acc__waddr & ALIGN_MASK;
                    axi4l__m_wdata   <= acc__wdata;
                    axi4l__m_awvalid <= 1'b1;
                    axi4l__m_wvalid  <= 1'b1;
                    wstate           <= W_ADDR;
                end
                W_ADDR: if (aw_ok && w_ok) begin
                    axi4l__m_bready <= 1'b1;
                    wstate          <= W_RESP;
                end
`ifdef AXI4L_M_TIMEOUT_EN
                else if (w_to_fire) begin
                    // Ready for B early so a late response can be drained.
                    axi4l__m_bready <= 1'b1;
                    acc__werr       <= 1'b1;
                    acc__wready     <= 1'b1;
                    wstate          <= W_DONE;
                end
`endif
                W_RESP: if (axi4l__m_bvalid) begin
                    acc__werr   <= (axi4l__m_bresp != 2'b00);
                    acc__wready <= 1'b1;
                    wstate      <= W_DONE;
                end
`ifdef AXI4L_M_TIMEOUT_EN
                else if (w_to_fire) begin
                    acc__werr   <= 1'b1;
                    acc__wready <= 1'b1;
                    wstate      <= W_DONE;
                end
`endif
                W_DONE: begin
                    acc__werr <= 1'b0;
`ifdef AXI4L_M_TIMEOUT_EN
                    if ((axi4l__m_awvalid && !axi4l__m_awready) || (axi4l__m_wvalid && !axi4l__m_wready) ||
                        (axi4l__m_bready && !axi4l__m_bvalid))
                        wstate <= W_DRAIN;
                    else
                        wstate <= W_IDLE;
`else
                    wstate <= W_IDLE;
`endif
                end
`ifdef AXI4L_M_TIMEOUT_EN
                W_DRAIN: if (!(axi4l__m_awvalid && !axi4l__m_awready) && !(axi4l__m_wvalid && !axi4l__m_wready) &&
                             !(axi4l__m_bready && !axi4l__m_bvalid))
                    wstate <= W_IDLE;
`endif
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel: AR then R; acc__rdata only updates on a real response.
    always_ff @(posedge sys__clk or posedge sys__arst) begin
        if (sys__arst) begin
            rstate           <= R_IDLE;
            axi4l__m_araddr  <= '0;
            axi4l__m_arvalid <= 1'b0;
            axi4l__m_rready  <= 1'b0;
            acc__rready      <= 1'b0;
            acc__rdata       <= '0;
            acc__rerr        <= 1'b0;
`ifdef AXI4L_M_TIMEOUT_EN
            rcnt             <= '0;
`endif
        end else begin
            if (axi4l__m_arvalid && axi4l__m_arready) axi4l__m_arvalid <= 1'b0;
            if (axi4l__m_rready && axi4l__m_rvalid)   axi4l__m_rready  <= 1'b0;
            acc__rready <= 1'b0;
`ifdef AXI4L_M_TIMEOUT_EN
            rcnt <= (rstate == R_ADDR || rstate == R_DATA) ? rcnt + 16'd1 : 16'd0;
`endif
            case (rstate)
                R_IDLE: if (acc__rvalid) begin
                    axi4l__m_araddr  <= acc__raddr & ALIGN_MASK;
                    axi4l__m_arvalid <= 1'b1;
                    rstate           <= R_ADDR;
                end
                R_ADDR: if (axi4l__m_arready) begin
                    axi4l__m_rready <= 1'b1;
                    rstate          <= R_DATA;
                end
`ifdef AXI4L_M_TIMEOUT_EN
                else if (r_to_fire) begin
                    axi4l__m_rready <= 1'b1;
                    acc__rerr       <= 1'b1;
                    acc__rready     <= 1'b1;
                    rstate          <= R_DONE;
                end
`endif
                R_DATA: if (axi4l__m_rvalid) begin
                    acc__rdata  <= axi4l__m_rdata;
                    acc__rerr   <= (axi4l__m_rresp != 2'b00);
                    acc__rready <= 1'b1;
                    rstate      <= R_DONE;
                end
`ifdef AXI4L_M_TIMEOUT_EN
                else if (r_to_fire) begin
                    acc__rerr   <= 1'b1;
                    acc__rready <= 1'b1;
                    rstate      <= R_DONE;
                end
`endif
                R_DONE: begin
                    acc__rerr <= 1'b0;
`ifdef AXI4L_M_TIMEOUT_EN
                    if ((axi4l__m_arvalid && !axi4l__m_arready) || (axi4l__m_rready && !axi4l__m_rvalid))
                        rstate <= R_DRAIN;
                    else
                        rstate <= R_IDLE;
`else
                    rstate <= R_IDLE;
`endif
                end
`ifdef AXI4L_M_TIMEOUT_EN
                R_DRAIN: if (!(axi4l__m_arvalid && !axi4l__m_arready) && !(axi4l__m_rready && !axi4l__m_rvalid))
                    rstate <= R_IDLE;
`endif
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l__aligned_acc_m_if.sv
// Directed self-checking bench for axi4l__aligned_acc_m_if with a small configurable AXI4-Lite slave.
// Define AXI4L_M_TIMEOUT_EN to also exercise the timeout/drain path.
module tb_axi4l__aligned_acc_m_if;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] acc__waddr = '0, acc__raddr = '0;
    logic [DW-1:0] acc__wdata = '0;
    logic          acc__wvalid = 1'b0, acc__rvalid = 1'b0;
    logic          acc__wready, acc__werr, acc__rready, acc__rerr;
    logic [DW-1:0] acc__rdata;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
    logic [1:0]    bresp = 0, rresp = 0;
    logic [DW-1:0] rdata = '0;
`ifdef AXI4L_M_TIMEOUT_EN
    logic          acc__timeout;
`endif

    axi4l__aligned_acc_m_if #(
        .axi4l__addr_width(AW), .axi4l__data_width(DW), .axi4l__prot(3'b000), .timeout_cycles(TO)
    ) dut (
        .sys__clk(clk), .sys__arst(rst),
        .acc__waddr(acc__waddr), .acc__wdata(acc__wdata), .acc__wvalid(acc__wvalid),
        .acc__wready(acc__wready), .acc__werr(acc__werr),
        .acc__raddr(acc__raddr), .acc__rvalid(acc__rvalid), .acc__rready(acc__rready),
        .acc__rdata(acc__rdata), .acc__rerr(acc__rerr),
        .axi4l__m_awaddr(awaddr), .axi4l__m_awprot(awprot), .axi4l__m_awvalid(awvalid), .axi4l__m_awready(awready),
        .axi4l__m_wdata(wdata), .axi4l__m_wstrb(wstrb), .axi4l__m_wvalid(wvalid), .axi4l__m_wready(wready),
        .axi4l__m_bresp(bresp), .axi4l__m_bvalid(bvalid), .axi4l__m_bready(bready),
        .axi4l__m_araddr(araddr), .axi4l__m_arprot(arprot), .axi4l__m_arvalid(arvalid), .axi4l__m_arready(arready),
        .axi4l__m_rdata(rdata), .axi4l__m_rresp(rresp), .axi4l__m_rvalid(rvalid), .axi4l__m_rready(rready)
`ifdef AXI4L_M_TIMEOUT_EN
        , .acc__timeout(acc__timeout)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration and observation state.
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0] b_resp_cfg = 0, r_resp_cfg = 0;
    logic [DW-1:0] r_data_cfg = '0;
    logic b_never = 0;
    logic aw_got = 0, w_got = 0, ar_got = 0;
    logic awvalid_q = 0, wvalid_q = 0, bready_q = 0, arvalid_q = 0, rready_q = 0;
    logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
    logic [DW-1:0] cap_wdata = '0;
    logic [DW/8-1:0] cap_wstrb = '0;
    logic w_first_seen = 0;
    int proto_err = 0, wr_pulses = 0, rd_pulses = 0;

    // Reactive slave: every handshake is detected one negedge after the posedge it happened on.
    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            awvalid_q = 0; wvalid_q = 0; bready_q = 0; arvalid_q = 0; rready_q = 0;
        end else begin
            if (acc__wready) wr_pulses++;
            if (acc__rready) rd_pulses++;
            if ((awvalid_q && !awvalid && !awready) || (wvalid_q && !wvalid && !wready) ||
                (arvalid_q && !arvalid && !arready)) proto_err++;
            if (awready && awvalid_q) begin
                aw_got = 1; awready = 0; cap_awaddr = awaddr;
            end else if (awvalid && !aw_got) begin
                if (aw_wait >= aw_delay) awready = 1; else aw_wait++;
            end
            if (wready && wvalid_q) begin
                w_got = 1; wready = 0; cap_wdata = wdata; cap_wstrb = wstrb;
            end else if (wvalid && !w_got) begin
                if (w_wait >= w_delay) wready = 1; else w_wait++;
            end
            if (w_got && !wvalid && awvalid) w_first_seen = 1;
            if (bvalid && bready_q) begin
                bvalid = 0; aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
            end else if (aw_got && w_got && !bvalid && !b_never) begin
                if (b_wait >= b_delay) begin bvalid = 1; bresp = b_resp_cfg; end else b_wait++;
            end
            if (arready && arvalid_q) begin
                ar_got = 1; arready = 0; cap_araddr = araddr;
            end else if (arvalid && !ar_got) begin
                if (ar_wait >= ar_delay) arready = 1; else ar_wait++;
            end
            if (rvalid && rready_q) begin
                rvalid = 0; ar_got = 0; ar_wait = 0; r_wait = 0;
            end else if (ar_got && !rvalid) begin
                if (r_wait >= r_delay) begin rvalid = 1; rdata = r_data_cfg; rresp = r_resp_cfg; end
                else r_wait++;
            end
            awvalid_q = awvalid; wvalid_q = wvalid; bready_q = bready; arvalid_q = arvalid; rready_q = rready;
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic exp_err, input int exp_lat);
        int n;
        int p0;
        p0 = wr_pulses;
        acc__waddr = a; acc__wdata = d; acc__wvalid = 1;
        n = 0;
        do begin step(); n++; end while (!acc__wready && n < 200);
        acc__wvalid = 0;
        check({tag, "_wready"}, 64'(acc__wready), 64'd1);
        check({tag, "_wlat"}, 64'(n), 64'(exp_lat));
        check({tag, "_werr"}, 64'(acc__werr), 64'(exp_err));
        step();
        check({tag, "_wpulse"}, 64'(wr_pulses - p0), 64'd1);
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp_data,
                           input logic exp_err, input int exp_lat);
        int n;
        int p0;
        p0 = rd_pulses;
        acc__raddr = a; acc__rvalid = 1;
        n = 0;
        do begin step(); n++; end while (!acc__rready && n < 200);
        acc__rvalid = 0;
        check({tag, "_rready"}, 64'(acc__rready), 64'd1);
        check({tag, "_rlat"}, 64'(n), 64'(exp_lat));
        check({tag, "_rdata"}, 64'(acc__rdata), 64'(exp_data));
        check({tag, "_rerr"}, 64'(acc__rerr), 64'(exp_err));
        step();
        check({tag, "_rpulse"}, 64'(rd_pulses - p0), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awvalid"}, 64'(awvalid), 64'd0);
        check({tag, "_wvalid"}, 64'(wvalid), 64'd0);
        check({tag, "_bready"}, 64'(bready), 64'd0);
        check({tag, "_arvalid"}, 64'(arvalid), 64'd0);
        check({tag, "_rready"}, 64'(rready), 64'd0);
        check({tag, "_accw"}, {62'd0, acc__wready, acc__werr}, 64'd0);
        check({tag, "_accr"}, {62'd0, acc__rready, acc__rerr}, 64'd0);
        check({tag, "_awaddr"}, awaddr, 64'd0);
        check({tag, "_wdata"}, 64'(wdata), 64'd0);
        check({tag, "_rdata"}, 64'(acc__rdata), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        repeat (3) step();
        check_idle_outputs("reset");
        check("reset_wstrb", 64'(wstrb), 64'hF);
        check("reset_prot", {58'd0, awprot, arprot}, 64'd0);
`ifdef AXI4L_M_TIMEOUT_EN
        check("reset_timeout", 64'(acc__timeout), 64'd0);
`endif
        rst = 0;
        step();

        // Zero-wait write, unaligned address.
        do_write("t1", 64'h1003, 32'hDEADBEEF, 1'b0, 3);
        check("t1_awaddr", cap_awaddr, 64'h1000);
        check("t1_wdata", 64'(cap_wdata), 64'hDEADBEEF);
        check("t1_wstrb", 64'(cap_wstrb), 64'hF);

        // W accepted 5 cycles before AW, SLVERR response.
        w_delay = 0; aw_delay = 5; b_resp_cfg = 2'b10; w_first_seen = 0;
        do_write("t2", 64'h3006, 32'h0000A5A5, 1'b1, 8);
        check("t2_awaddr", cap_awaddr, 64'h3004);
        check("t2_w_before_aw", 64'(w_first_seen), 64'd1);
        check("t2_protocol", 64'(proto_err), 64'd0);
        aw_delay = 0; b_resp_cfg = 2'b00;

        // Read with delayed AR; data must hold afterwards.
        ar_delay = 2; r_data_cfg = 32'h12345678; r_resp_cfg = 2'b00;
        do_read("t3", 64'h2002, 32'h12345678, 1'b0, 5);
        check("t3_araddr", cap_araddr, 64'h2000);
        rdata = 32'hAAAA5555;
        repeat (3) step();
        check("t3_rdata_hold", 64'(acc__rdata), 64'h12345678);
        ar_delay = 0;

        // Concurrent write and read issued the same cycle.
        r_data_cfg = 32'h0BADF00D; r_resp_cfg = 2'b11;
        fork
            do_write("t4", 64'h4000, 32'hCAFEF00D, 1'b0, 3);
            do_read("t4", 64'h5008, 32'h0BADF00D, 1'b1, 3);
        join
        check("t4_awaddr", cap_awaddr, 64'h4000);
        check("t4_araddr", cap_araddr, 64'h5008);
        r_resp_cfg = 2'b00;

        // Asynchronous reset while the write FSM waits in RESP.
        b_never = 1; p0 = wr_pulses;
        acc__waddr = 64'h7000; acc__wdata = 32'h11112222; acc__wvalid = 1;
        n = 0;
        do begin step(); n++; end while (!bready && n < 50);
        check("t5_in_resp", 64'(bready), 64'd1);
        #2 rst = 1;
        #1 check_idle_outputs("t5_async");
        acc__wvalid = 0;
        step();
        rst = 0; b_never = 0;
        step();
        check("t5_no_pulse", 64'(wr_pulses - p0), 64'd0);
        do_write("t5_after", 64'h8004, 32'h33334444, 1'b0, 3);
        check("t5_awaddr", cap_awaddr, 64'h8004);
        check("t5_wdata", 64'(cap_wdata), 64'h33334444);

`ifdef AXI4L_M_TIMEOUT_EN
        // Slave never answers B: timeout at count TO-1, then drain until a late bvalid.
        b_never = 1;
        do_write("t6", 64'h6000, 32'h55556666, 1'b1, 17);
        check("t6_timeout", 64'(acc__timeout), 64'd1);
        repeat (3) step();
        check("t6_drain_bready", 64'(bready), 64'd1);
        b_never = 0;
        n = 0;
        do begin step(); n++; end while (bready && n < 50);
        check("t6_drained", 64'(bready), 64'd0);
        check("t6_timeout_sticky", 64'(acc__timeout), 64'd1);
        do_write("t6_after", 64'h6100, 32'h77778888, 1'b0, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
